div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle sequencer for the RV32M divide group (DIV, DIVU, REM, REMU), placed beside the execute stage. It accepts one division per handshake, runs a radix-2 restoring loop of 32 iterations, and holds the pipeline through `stall_o` while busy. When finished, it presents the result with a register-write request for the execute stage to forward to exe_mem. Divide-by-zero and signed-overflow cases complete early with RISC-V-defined results.

## Interface
- `DATA_WIDTH`, 32: operand and result width; the iteration count equals `DATA_WIDTH`.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  request a division; sampled only in IDLE or DONE.
- `op_i`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend_i`  in  DATA_WIDTH  rs1 value.
- `divisor_i`  in  DATA_WIDTH  rs2 value.
- `reg_waddr_i`  in  RADDR_WIDTH  destination register.
- `flush_i`  in  1  abort the operation in flight; no result is produced.
- `stall_o`  out  1  freeze the upstream pipeline; combinational.
- `busy_o`  out  1  state is CALC.
- `done_o`  out  1  one-cycle result-valid pulse.
- `result_o`  out  DATA_WIDTH  quotient or remainder; valid while `done_o` is high.
- `reg_waddr_o`  out  RADDR_WIDTH  latched destination register.
- `reg_we_o`  out  1  equals `done_o` when `reg_waddr_o` is non-zero; 0 when the destination is x0.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: all outputs 0, the counter is 0, and all internal registers are 0.
- Accepting a start (IDLE, or DONE for back-to-back operation):
  - Latch `op_i` and `reg_waddr_i`.
  - For DIV/REM, take the absolute values of both operands. Record `neg_q` = sign(dividend) XOR sign(divisor) and `neg_r` = sign(dividend).
  - For DIVU/REMU, use the operands unmodified.
- Divisor == 0:
  - Go directly to DONE.
  - Quotient = all ones; remainder = dividend (original, unsigned-magnitude path not applied).
- Signed overflow (DIV/REM, dividend = 0x8000_0000, divisor = 0xFFFF_FFFF):
  - Go directly to DONE.
  - Quotient = 0x8000_0000; remainder = 0.
- All other cases: go to CALC with counter = `DATA_WIDTH`-1.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper half (`DATA_WIDTH`+1-bit subtraction).
  - If the result is non-negative, commit it and set quo[0] = 1.
  - Decrement the counter. When the counter reaches 0, go to DONE.
- DONE:
  - `done_o` = 1.
  - `result_o` = quotient (op 00/01) or remainder (op 10/11).
  - Apply the sign correction: negate the quotient if `neg_q`, negate the remainder if `neg_r`.
  - With no `start_i`, go to IDLE.
- `stall_o` = (state == CALC) OR (state ∈ {IDLE, DONE} AND `start_i`).
  - It is low in the DONE cycle when no new start arrives, so the pipeline captures the result.
- `flush_i`: takes priority over everything except reset.
  - In any state, go to IDLE with `done_o` and `reg_we_o` = 0 on the next cycle.
  - A `start_i` in the same cycle is ignored.
- `start_i` while in CALC is ignored; the caller is stalled and cannot issue.

## Timing
- Start sampled at edge 0.
  - Normal case: CALC during cycles 1–32, `done_o` in cycle 33. Total latency is 33 cycles.
  - Early case (divide-by-zero or overflow): `done_o` in cycle 1.
- Back-to-back: a start in the DONE cycle enters CALC or DONE on the next edge without passing through IDLE.
- `result_o`, `reg_waddr_o` and `reg_we_o` are registered or derived from registered state only. No combinational path runs from the operands to the outputs.
- Asynchronous reset asserted mid-CALC: IDLE immediately, and outputs are 0 before the next edge.

## Structure
- The op encodings `DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM` and `DIV_OP_REMU`, and the state encodings, are added to defines.v. The existing `DATA_WIDTH`, `RADDR_WIDTH`, `ZERO` and `WRITE_DISABLE` come from defines.v.
- One sub-module: `div_step`, the combinational single-iteration shift/trial-subtract, producing the next {rem, quo}.
- The sequencer holds the FSM, counter, operand latches and sign fix-up.

## Test plan
- DIVU 100 / 7, rd=5 → `done_o` at cycle 33, `result_o` = 14, `reg_waddr_o` = 5, `reg_we_o` = 1; `stall_o` high during cycles 0–32.
- REM -7 / 2 → `result_o` = 0xFFFF_FFFF (-1); DIV -7 / 2 → 0xFFFF_FFFD (-3).
- DIV 5 / 0 → `done_o` at cycle 1, `result_o` = 0xFFFF_FFFF; REMU 5 / 0 → 5.
- DIV 0x8000_0000 / 0xFFFF_FFFF → `done_o` at cycle 1, result 0x8000_0000; REM of the same operands → 0.
- Start a DIVU, pulse `flush_i` at cycle 10 → IDLE at cycle 11, no `done_o`, `stall_o` = 0. Repeat with `rst_i` asserted at cycle 10 → all outputs 0 asynchronously.
- Two back-to-back DIVUs (start again in the DONE cycle), the second with rd=0 → two `done_o` pulses 33 cycles apart; the second has `reg_we_o` = 0.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared widths, constants and encodings for the RV32M divide sequencer.
// The divide op and FSM state encodings live here beside the datapath widths.
package div_sequencer_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int CNT_WIDTH   = $clog2(DATA_WIDTH);

  localparam logic [DATA_WIDTH-1:0] ZERO          = '0;
  localparam logic                  WRITE_DISABLE = 1'b0;
  localparam logic [DATA_WIDTH-1:0] INT_MIN       = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_S_IDLE = 2'b00,
    DIV_S_CALC = 2'b01,
    DIV_S_DONE = 2'b10
  } div_state_e;

  // Two's-complement magnitude; INT_MIN maps onto itself, which is the correct
  // unsigned magnitude.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? (ZERO - v) : v;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
// master = execute stage side, slave = sequencer side.
interface div_sequencer_if;
  import div_sequencer_pkg::*;

  logic                   start;
  div_op_e                op;
  logic [DATA_WIDTH-1:0]  dividend;
  logic [DATA_WIDTH-1:0]  divisor;
  logic [RADDR_WIDTH-1:0] dest_addr;
  logic                   flush;

  logic                   stall;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  result;
  logic [RADDR_WIDTH-1:0] reg_waddr;
  logic                   reg_we;

  modport master (
    output start, op, dividend, divisor, dest_addr, flush,
    input  stall, busy, done, result, reg_waddr, reg_we
  );

  modport slave (
    input  start, op, dividend, divisor, dest_addr, flush,
    output stall, busy, done, result, reg_waddr, reg_we
  );

endinterface

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the
// divisor from the upper half and commit on a non-negative result.
module div_step
  import div_sequencer_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  // The shifted remainder can exceed DATA_WIDTH bits when the divisor is large,
  // so the trial subtraction runs one bit wider and bit DATA_WIDTH is the sign.
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;

  assign shifted  = {rem, quo[DATA_WIDTH-1]};
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = trial[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
  assign quo_next = {quo[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: 32-iteration restoring loop with
// early completion for divide-by-zero and signed overflow.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  div_sequencer_if.slave      bus
);

  div_state_e             state, state_next;
  logic [CNT_WIDTH-1:0]   cnt;
  div_op_e                op_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]  rem_q, quo_q, divisor_q;
  logic                   neg_q, neg_r;
  logic [DATA_WIDTH-1:0]  rem_next, quo_next;
  logic [DATA_WIDTH-1:0]  fixed_result;

  logic idle_or_done, accept, is_signed, div_zero, overflow;

  assign idle_or_done = (state == DIV_S_IDLE) || (state == DIV_S_DONE);
  assign accept       = idle_or_done && bus.start && !bus.flush;
  assign is_signed    = !bus.op[0];
  assign div_zero     = (bus.divisor == ZERO);
  assign overflow     = is_signed && (bus.dividend == INT_MIN) && (bus.divisor == '1);

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_S_IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all registers update
      // from the same pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned
    // and infers a latch.
    state_next = state;
    unique case (state)
      DIV_S_IDLE, DIV_S_DONE: begin
        if (accept) state_next = (div_zero || overflow) ? DIV_S_DONE : DIV_S_CALC;
        else        state_next = DIV_S_IDLE;
      end
      DIV_S_CALC: if (cnt == '0) state_next = DIV_S_DONE;
      default:    state_next = DIV_S_IDLE;
    endcase
    if (bus.flush) state_next = DIV_S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= DIV_OP_DIV;
      waddr_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.op;
      waddr_q <= bus.dest_addr;
      if (div_zero) begin
        quo_q <= '1;
        rem_q <= bus.dividend;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (overflow) begin
        quo_q <= INT_MIN;
        rem_q <= ZERO;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        quo_q     <= is_signed ? abs_val(bus.dividend) : bus.dividend;
        divisor_q <= is_signed ? abs_val(bus.divisor)  : bus.divisor;
        rem_q     <= ZERO;
        neg_q     <= is_signed && (bus.dividend[DATA_WIDTH-1] ^ bus.divisor[DATA_WIDTH-1]);
        neg_r     <= is_signed && bus.dividend[DATA_WIDTH-1];
        cnt       <= CNT_WIDTH'(DATA_WIDTH - 1);
      end
    end else if ((state == DIV_S_CALC) && !bus.flush) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt   <= cnt - 1'b1;
    end
  end

  always_comb begin
    if (op_q[1]) fixed_result = neg_r ? (ZERO - rem_q) : rem_q;
    else         fixed_result = neg_q ? (ZERO - quo_q) : quo_q;
  end

  // Result is gated by DONE so the bus reads zero outside the valid cycle.
  assign bus.done      = (state == DIV_S_DONE);
  assign bus.busy      = (state == DIV_S_CALC);
  assign bus.stall     = (state == DIV_S_CALC) || (idle_or_done && bus.start);
  assign bus.result    = bus.done ? fixed_result : ZERO;
  assign bus.reg_waddr = waddr_q;
  assign bus.reg_we    = (bus.done && (waddr_q != '0)) ? 1'b1 : WRITE_DISABLE;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with hand-computed vectors.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   stall_err = 0;

  div_sequencer_if bus ();

  div_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive a start at the current negedge; it is sampled at the next posedge (edge 0).
  task automatic start_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.dest_addr = rd;
    #1;
    if (bus.stall !== 1'b1) stall_err++;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts negedges after edge 0 until done; -1 on timeout. Tracks stall behaviour.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (bus.stall !== 1'b0) stall_err++;
        cyc = i;
        return;
      end
      if (bus.stall !== 1'b1) stall_err++;
    end
  endtask

  task automatic run_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int cyc, output logic [31:0] res,
                        output logic we, output logic [4:0] wa);
    @(negedge clk);
    start_op(op, a, b, rd);
    wait_done(cyc);
    res = bus.result;
    we  = bus.reg_we;
    wa  = bus.reg_waddr;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = DIV_OP_DIV; bus.dividend = '0; bus.divisor = '0;
    bus.dest_addr = '0; bus.flush = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.stall, bus.busy, bus.done, bus.reg_we} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000", {bus.stall, bus.busy, bus.done, bus.reg_we});
    end
    n_vec++;
    if (bus.result !== 32'h0 || bus.reg_waddr !== 5'd0) begin
      n_err++; $display("FAIL reset_data: result=%h waddr=%0d want 0/0", bus.result, bus.reg_waddr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++; $display("FAIL reset_release: busy/done=%b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_divu_basic;
    int cyc; logic [31:0] res; logic we; logic [4:0] wa;
    stall_err = 0;
    run_op(DIV_OP_DIVU, 32'd100, 32'd7, 5'd5, cyc, res, we, wa);
    n_vec++;
    if (cyc !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", cyc); end
    n_vec++;
    if (res !== 32'd14) begin n_err++; $display("FAIL divu_result: got %0d want 14", res); end
    n_vec++;
    if (wa !== 5'd5 || we !== 1'b1) begin
      n_err++; $display("FAIL divu_wb: waddr=%0d we=%b want 5/1", wa, we);
    end
    n_vec++;
    if (stall_err != 0) begin n_err++; $display("FAIL divu_stall: %0d bad cycles want 0", stall_err); end
    @(negedge clk);
    n_vec++;
    if (bus.done !== 1'b0 || bus.reg_we !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b we=%b want 0/0 after pulse", bus.done, bus.reg_we);
    end
  endtask

  typedef struct {
    div_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  task automatic test_vectors;
    vec_t v[11];
    int cyc; logic [31:0] res; logic we; logic [4:0] wa;
    v[0]  = '{DIV_OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};
    v[1]  = '{DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33};
    v[2]  = '{DIV_OP_DIV,  32'd5,        32'd0,        32'hFFFF_FFFF, 1};
    v[3]  = '{DIV_OP_REMU, 32'd5,        32'd0,        32'd5,         1};
    v[4]  = '{DIV_OP_REM,  32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1};
    v[5]  = '{DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[6]  = '{DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    v[7]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         33};
    v[8]  = '{DIV_OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         33};
    v[9]  = '{DIV_OP_DIV,  32'd20,       32'hFFFF_FFFA, 32'hFFFF_FFFD, 33};
    v[10] = '{DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         33};
    for (int i = 0; i < 11; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'd3, cyc, res, we, wa);
      n_vec++;
      if (cyc !== v[i].cyc || res !== v[i].exp) begin
        n_err++;
        $display("FAIL vec%0d op=%0d %h/%h: result=%h cyc=%0d want %h cyc=%0d",
                 i, v[i].op, v[i].a, v[i].b, res, cyc, v[i].exp, v[i].cyc);
      end
    end
  endtask

  task automatic test_flush;
    bit seen_done = 0;
    @(negedge clk);
    start_op(DIV_OP_DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.stall, bus.reg_we} !== 4'b0000) begin
      n_err++; $display("FAIL flush_idle: busy/done/stall/we=%b want 0000",
                        {bus.busy, bus.done, bus.stall, bus.reg_we});
    end
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen_done = 1;
    end
    n_vec++;
    if (seen_done) begin n_err++; $display("FAIL flush_nodone: done seen=1 want 0"); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    start_op(DIV_OP_DIVU, 32'd1000, 32'd3, 5'd9);
    repeat (10) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL areset_pre: busy=%b want 1", bus.busy); end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus.stall, bus.busy, bus.done, bus.reg_we} !== 4'b0000 ||
        bus.result !== 32'h0 || bus.reg_waddr !== 5'd0) begin
      n_err++; $display("FAIL areset_outputs: ctrl=%b result=%h waddr=%0d want 0",
                        {bus.stall, bus.busy, bus.done, bus.reg_we}, bus.result, bus.reg_waddr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc1, cyc2; logic [31:0] res1, res2; logic we1, we2; logic [4:0] wa2;
    run_op(DIV_OP_DIVU, 32'd50, 32'd5, 5'd4, cyc1, res1, we1, wa2);
    // Still in the DONE cycle: issue the second operation immediately.
    start_op(DIV_OP_DIVU, 32'd81, 32'd9, 5'd0);
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_direct_calc: busy=%b want 1", bus.busy);
    end
    wait_done(cyc2);
    res2 = bus.result;
    we2  = bus.reg_we;
    wa2  = bus.reg_waddr;
    n_vec++;
    if (cyc1 !== 33 || res1 !== 32'd10 || we1 !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: cyc=%0d result=%0d we=%b want 33/10/1", cyc1, res1, we1);
    end
    n_vec++;
    if (cyc2 !== 33 || res2 !== 32'd9) begin
      n_err++; $display("FAIL b2b_second: cyc=%0d result=%0d want 33/9", cyc2, res2);
    end
    n_vec++;
    if (we2 !== 1'b0 || wa2 !== 5'd0) begin
      n_err++; $display("FAIL b2b_x0: we=%b waddr=%0d want 0/0", we2, wa2);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_vectors();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
